// File: rtl/playfield_pixel_reader_pkg.sv
// Shared geometry defaults, palette colours and cell-code constants for the
// playfield pixel reader.
package playfield_pixel_reader_pkg;

  localparam int X_MAP  = 235;
  localparam int Y_MAP  = 10;
  localparam int CELL_W = 19;
  localparam int CELL_H = 23;
  localparam int COLS   = 10;
  localparam int ROWS   = 20;
  localparam int CODE_W = 5;

  localparam logic [7:0] BG_LEVEL  = 8'd90;
  localparam logic [7:0] OUT_LEVEL = 8'd34;

  // Codes 10..19 are the falling-piece copies of colours 0..9.
  localparam logic [CODE_W-1:0] FALL_OFFSET = 5'd10;
  localparam logic [CODE_W-1:0] CODE_LIMIT  = 5'd20;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t PAL_BG     = '{r: BG_LEVEL,  g: BG_LEVEL,  b: BG_LEVEL};
  localparam rgb_t PAL_OUT    = '{r: OUT_LEVEL, g: OUT_LEVEL, b: OUT_LEVEL};
  localparam rgb_t PAL_WHITE  = '{r: 8'd255, g: 8'd255, b: 8'd255};
  localparam rgb_t PAL_CYAN   = '{r: 8'd0,   g: 8'd255, b: 8'd255};
  localparam rgb_t PAL_YELLOW = '{r: 8'd255, g: 8'd255, b: 8'd0};
  localparam rgb_t PAL_PURPLE = '{r: 8'd128, g: 8'd0,   b: 8'd128};
  localparam rgb_t PAL_GREEN  = '{r: 8'd0,   g: 8'd255, b: 8'd0};
  localparam rgb_t PAL_RED    = '{r: 8'd255, g: 8'd0,   b: 8'd0};
  localparam rgb_t PAL_BLUE   = '{r: 8'd0,   g: 8'd0,   b: 8'd255};
  localparam rgb_t PAL_ORANGE = '{r: 8'd255, g: 8'd127, b: 8'd0};
  localparam rgb_t PAL_GREY   = '{r: 8'd127, g: 8'd127, b: 8'd127};

endpackage

// File: rtl/playfield_palette.sv
// Combinational cell-code to RGB lookup; falling-piece codes share the colour
// of their base code, and unused codes render as the empty-cell grey.
module playfield_palette
  import playfield_pixel_reader_pkg::*;
(
  input  logic [CODE_W-1:0] code_i,
  output rgb_t              rgb_o
);

  logic [CODE_W-1:0] base;

  always_comb begin
    base  = (code_i >= FALL_OFFSET) ? code_i - FALL_OFFSET : code_i;
    rgb_o = PAL_BG;
    if (code_i < CODE_LIMIT) begin
      case (base)
        5'd1:    rgb_o = PAL_WHITE;
        5'd2:    rgb_o = PAL_CYAN;
        5'd3:    rgb_o = PAL_YELLOW;
        5'd4:    rgb_o = PAL_PURPLE;
        5'd5:    rgb_o = PAL_GREEN;
        5'd6:    rgb_o = PAL_RED;
        5'd7:    rgb_o = PAL_BLUE;
        5'd8:    rgb_o = PAL_ORANGE;
        5'd9:    rgb_o = PAL_GREY;
        default: rgb_o = PAL_BG;
      endcase
    end
  end

endmodule

// File: rtl/playfield_pixel_reader.sv
// Playfield read side: fetches one map row per VGA line into a row buffer and
// converts pixel coordinates to RGB through a fixed two-stage pipeline.
module playfield_pixel_reader
  import playfield_pixel_reader_pkg::*;
(
  input  logic                   vga_clk_i,
  input  logic                   reset_i,
  input  logic [11:0]            pix_x_i,
  input  logic [11:0]            pix_y_i,
  input  logic                   hs_i,
  input  logic                   vs_i,
  input  logic                   active_i,
  output logic                   row_rd_o,
  output logic [4:0]             row_addr_o,
  input  logic [COLS*CODE_W-1:0] row_data_i,
  output logic [7:0]             vga_r_o,
  output logic [7:0]             vga_g_o,
  output logic [7:0]             vga_b_o,
  output logic                   hs_o,
  output logic                   vs_o,
  output logic                   active_o
);

  localparam logic [11:0] X_LO     = 12'(X_MAP);
  localparam logic [11:0] X_HI     = 12'(X_MAP + COLS * CELL_W);
  localparam logic [11:0] Y_LO     = 12'(Y_MAP);
  localparam logic [11:0] Y_HI     = 12'(Y_MAP + ROWS * CELL_H);
  localparam logic [4:0]  SUBX_MAX = 5'(CELL_W - 1);
  localparam logic [4:0]  SUBY_MAX = 5'(CELL_H - 1);
  localparam logic [4:0]  ROW_MAX  = 5'(ROWS - 1);
  localparam logic [3:0]  COL_MAX  = 4'(COLS - 1);

  logic                   synced_q, synced_d;
  logic [4:0]             row_q, row_d;
  logic [4:0]             suby_q, suby_d;
  logic [3:0]             col_q, col_d;
  logic [4:0]             subx_q, subx_d;
  logic                   row_rd_q;
  logic [4:0]             row_addr_q;
  logic                   fetch_q;
  logic [COLS*CODE_W-1:0] row_buf_q;

  logic       s1_in_region_q, s1_hs_q, s1_vs_q, s1_active_q;
  logic [3:0] s1_col_q;
  rgb_t       rgb_q, rgb_d;
  logic       hs_q, vs_q, active_q;

  logic              line_start, x_in, y_in, in_region;
  logic [CODE_W-1:0] cell_code;
  rgb_t              pal_rgb;

  always_comb begin
    line_start = (pix_x_i == 12'd0);
    x_in       = (pix_x_i >= X_LO) && (pix_x_i < X_HI);
    y_in       = (pix_y_i >= Y_LO) && (pix_y_i < Y_HI);
    in_region  = x_in && y_in && synced_q;

    synced_d = synced_q;
    row_d    = row_q;
    suby_d   = suby_q;
    if (line_start) begin
      if (pix_y_i == Y_LO) begin
        row_d    = 5'd0;
        suby_d   = 5'd0;
        synced_d = 1'b1;
      end else if (synced_q && (pix_y_i > Y_LO) && (pix_y_i < Y_HI)) begin
        if (suby_q == SUBY_MAX) begin
          suby_d = 5'd0;
          if (row_q != ROW_MAX) row_d = row_q + 5'd1;
        end else begin
          suby_d = suby_q + 5'd1;
        end
      end
    end

    // Column state describes the pixel being presented, so it is resolved
    // combinationally from the previous pixel's counters.
    col_d  = col_q;
    subx_d = subx_q;
    if (pix_x_i == X_LO) begin
      col_d  = 4'd0;
      subx_d = 5'd0;
    end else if (x_in) begin
      if (subx_q == SUBX_MAX) begin
        subx_d = 5'd0;
        if (col_q != COL_MAX) col_d = col_q + 4'd1;
      end else begin
        subx_d = subx_q + 5'd1;
      end
    end
  end

  always_comb begin
    cell_code = '0;
    for (int j = 0; j < COLS; j++) begin
      if (s1_col_q == 4'(j)) cell_code = row_buf_q[j*CODE_W +: CODE_W];
    end
  end

  playfield_palette u_palette (
    .code_i (cell_code),
    .rgb_o  (pal_rgb)
  );

  always_comb begin
    rgb_d = '0;
    if (s1_active_q) rgb_d = s1_in_region_q ? pal_rgb : PAL_OUT;
  end

  always_ff @(posedge vga_clk_i) begin
    if (reset_i) begin
      synced_q       <= 1'b0;
      row_q          <= '0;
      suby_q         <= '0;
      col_q          <= '0;
      subx_q         <= '0;
      row_rd_q       <= 1'b0;
      row_addr_q     <= '0;
      fetch_q        <= 1'b0;
      row_buf_q      <= '0;
      s1_in_region_q <= 1'b0;
      s1_col_q       <= '0;
      s1_hs_q        <= 1'b1;
      s1_vs_q        <= 1'b1;
      s1_active_q    <= 1'b0;
      rgb_q          <= '0;
      hs_q           <= 1'b1;
      vs_q           <= 1'b1;
      active_q       <= 1'b0;
    end else begin
      synced_q <= synced_d;
      row_q    <= row_d;
      suby_q   <= suby_d;
      col_q    <= col_d;
      subx_q   <= subx_d;
      row_rd_q <= line_start;
      if (line_start) row_addr_q <= (row_d > ROW_MAX) ? ROW_MAX : row_d;
      // Map memory answers one cycle after the strobe; snapshot held all line.
      fetch_q <= row_rd_q;
      if (fetch_q) row_buf_q <= row_data_i;

      s1_in_region_q <= in_region;
      s1_col_q       <= col_d;
      s1_hs_q        <= hs_i;
      s1_vs_q        <= vs_i;
      s1_active_q    <= active_i;

      rgb_q    <= rgb_d;
      hs_q     <= s1_hs_q;
      vs_q     <= s1_vs_q;
      active_q <= s1_active_q;
    end
  end

  assign row_rd_o   = row_rd_q;
  assign row_addr_o = row_addr_q;
  assign vga_r_o    = rgb_q.r;
  assign vga_g_o    = rgb_q.g;
  assign vga_b_o    = rgb_q.b;
  assign hs_o       = hs_q;
  assign vs_o       = vs_q;
  assign active_o   = active_q;

endmodule

// File: tb/tb_playfield_pixel_reader.sv
// Scoreboard bench for playfield_pixel_reader: directed VGA lines with
// hand-computed colours, a row-memory model and a two-cycle-latency monitor.
module tb_playfield_pixel_reader;

  localparam logic [23:0] C_OUT    = 24'h222222;
  localparam logic [23:0] C_BG     = 24'h5A5A5A;
  localparam logic [23:0] C_WHITE  = 24'hFFFFFF;
  localparam logic [23:0] C_CYAN   = 24'h00FFFF;
  localparam logic [23:0] C_RED    = 24'hFF0000;
  localparam logic [23:0] C_ORANGE = 24'hFF7F00;
  localparam logic [23:0] C_PURPLE = 24'h800080;
  localparam logic [23:0] C_GREY   = 24'h7F7F7F;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] pix_x, pix_y;
  logic        hs, vs, act;
  logic [49:0] row_data;
  logic        row_rd_o;
  logic [4:0]  row_addr_o;
  logic [7:0]  vga_r_o, vga_g_o, vga_b_o;
  logic        hs_o, vs_o, active_o;

  always #5 clk = ~clk;

  playfield_pixel_reader dut (
    .vga_clk_i  (clk),
    .reset_i    (rst),
    .pix_x_i    (pix_x),
    .pix_y_i    (pix_y),
    .hs_i       (hs),
    .vs_i       (vs),
    .active_i   (act),
    .row_rd_o   (row_rd_o),
    .row_addr_o (row_addr_o),
    .row_data_i (row_data),
    .vga_r_o    (vga_r_o),
    .vga_g_o    (vga_g_o),
    .vga_b_o    (vga_b_o),
    .hs_o       (hs_o),
    .vs_o       (vs_o),
    .active_o   (active_o)
  );

  typedef struct packed {
    logic        chk;
    logic [23:0] rgb;
    logic        hs;
    logic        vs;
    logic        act;
  } exp_t;

  typedef struct {
    int          x;
    logic [23:0] rgb;
  } pchk_t;

  exp_t        sb_q[$];
  pchk_t       pl[$];
  logic [49:0] map_mem [0:19];
  int          checks   = 0;
  int          failures = 0;
  int          rd_cnt   = 0;

  task automatic check(input string name, input logic [23:0] got, input logic [23:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t y=%0d)", name, got, want, $time, pix_y);
    end
  endtask

  // Monitor: every output cycle corresponds to the stimulus two cycles earlier.
  exp_t e;
  always @(negedge clk) begin
    if (row_rd_o) rd_cnt++;
    if (sb_q.size() == 3) begin
      e = sb_q.pop_front();
      check("hs_delay", 24'(hs_o), 24'(e.hs));
      check("vs_delay", 24'(vs_o), 24'(e.vs));
      check("active_delay", 24'(active_o), 24'(e.act));
      if (e.chk) check("rgb", {vga_r_o, vga_g_o, vga_b_o}, e.rgb);
    end
  end

  // Row memory: data valid the cycle after the strobe, garbage afterwards.
  logic [4:0] mem_a;
  always begin
    @(negedge clk);
    if (row_rd_o) begin
      mem_a = row_addr_o;
      @(posedge clk);
      #1 row_data = map_mem[mem_a];
      @(posedge clk);
      #1 row_data = '1;
    end
  end

  task automatic drive(input int x, input int y, input logic h, input logic v,
                       input logic a, input logic c, input logic [23:0] rgb);
    pix_x = 12'(x);
    pix_y = 12'(y);
    hs    = h;
    vs    = v;
    act   = a;
    sb_q.push_back({c, rgb, h, v, a});
    @(posedge clk);
    #1;
  endtask

  task automatic add_chk(input int x, input logic [23:0] rgb);
    pchk_t p;
    p.x   = x;
    p.rgb = rgb;
    pl.push_back(p);
  endtask

  task automatic do_line(input int y, input logic full, input logic chk_addr, input int exp_addr);
    logic        v, c;
    logic [23:0] rgb;
    v = (y < 2) ? 1'b0 : 1'b1;
    rd_cnt = 0;
    drive(0, y, 1'b1, v, 1'b1, 1'b1, C_OUT);
    if (chk_addr) begin
      check("row_rd", 24'(row_rd_o), 24'd1);
      check("row_addr", 24'(row_addr_o), 24'(exp_addr));
    end
    for (int x = 1; x < 5; x++) drive(x, y, 1'b1, v, 1'b1, 1'b1, C_OUT);
    if (full) begin
      for (int x = 230; x <= 440; x++) begin
        c   = 1'b0;
        rgb = '0;
        foreach (pl[i]) if (pl[i].x == x) begin c = 1'b1; rgb = pl[i].rgb; end
        drive(x, y, 1'b1, v, 1'b1, c, rgb);
      end
    end
    drive(640, y, 1'b0, v, 1'b0, 1'b1, 24'h0);
    drive(641, y, 1'b0, v, 1'b0, 1'b1, 24'h0);
    check("rd_once", 24'(rd_cnt), 24'd1);
  endtask

  task automatic do_reset();
    sb_q.delete();
    rst   = 1'b1;
    hs    = 1'b0;
    vs    = 1'b0;
    act   = 1'b1;
    pix_x = 12'd5;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rgb", {vga_r_o, vga_g_o, vga_b_o}, 24'h0);
    check("rst_hs", 24'(hs_o), 24'd1);
    check("rst_vs", 24'(vs_o), 24'd1);
    check("rst_active", 24'(active_o), 24'd0);
    check("rst_row_rd", 24'(row_rd_o), 24'd0);
    check("rst_row_addr", 24'(row_addr_o), 24'd0);
    rst = 1'b0;
  endtask

  task automatic row0_checks();
    pl.delete();
    add_chk(235, C_WHITE);
    add_chk(253, C_WHITE);
    add_chk(254, C_BG);
    add_chk(300, C_BG);
    add_chk(406, C_CYAN);
    add_chk(424, C_CYAN);
    add_chk(425, C_OUT);
    add_chk(230, C_OUT);
  endtask

  initial begin
    rst      = 1'b1;
    pix_x    = 12'd5;
    pix_y    = 12'd0;
    hs       = 1'b1;
    vs       = 1'b1;
    act      = 1'b0;
    row_data = '0;
    for (int i = 0; i < 20; i++) map_mem[i] = '0;
    map_mem[0]  = (50'd2 << 45) | 50'd11;
    map_mem[1]  = (50'd4 << 25) | (50'd25 << 20) | (50'd18 << 15) | (50'd16 << 10);
    map_mem[19] = (50'd9 << 45) | 50'd1;
    @(posedge clk);
    #1;

    do_reset();
    for (int y = 0; y < 10; y++) do_line(y, 1'b0, 1'b0, 0);
    row0_checks();
    do_line(10, 1'b1, 1'b1, 0);
    for (int y = 11; y < 33; y++) do_line(y, 1'b0, 1'b0, 0);

    pl.delete();
    add_chk(235, C_BG);
    add_chk(273, C_RED);
    add_chk(292, C_ORANGE);
    add_chk(310, C_ORANGE);
    add_chk(311, C_BG);
    add_chk(330, C_PURPLE);
    do_line(33, 1'b1, 1'b1, 1);
    for (int y = 34; y < 469; y++) begin
      if (y == 56)       do_line(y, 1'b0, 1'b1, 2);
      else if (y == 447) do_line(y, 1'b0, 1'b1, 19);
      else               do_line(y, 1'b0, 1'b0, 0);
    end

    pl.delete();
    add_chk(235, C_WHITE);
    add_chk(254, C_BG);
    add_chk(406, C_GREY);
    add_chk(424, C_GREY);
    add_chk(425, C_OUT);
    do_line(469, 1'b1, 1'b1, 19);
    pl.delete();
    add_chk(235, C_OUT);
    add_chk(406, C_OUT);
    do_line(470, 1'b1, 1'b1, 19);
    for (int y = 471; y < 480; y++) do_line(y, 1'b0, 1'b0, 0);

    // Second frame: reset mid-frame leaves the playfield grey until resync.
    for (int y = 0; y < 100; y++) do_line(y, 1'b0, 1'b0, 0);
    do_reset();
    for (int y = 101; y < 150; y++) do_line(y, 1'b0, 1'b0, 0);
    pl.delete();
    add_chk(235, C_OUT);
    add_chk(300, C_OUT);
    add_chk(406, C_OUT);
    do_line(150, 1'b1, 1'b1, 0);
    for (int y = 151; y < 480; y++) do_line(y, 1'b0, 1'b0, 0);

    for (int y = 0; y < 10; y++) do_line(y, 1'b0, 1'b0, 0);
    row0_checks();
    do_line(10, 1'b1, 1'b1, 0);
    for (int i = 0; i < 4; i++) drive(700, 11, 1'b1, 1'b1, 1'b0, 1'b1, 24'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
